sobel_stream_det: RTL
=====================

SOBEL_STREAM_DET -- requirements
Module: sobel_stream_det

Interface
REQ-001 The block SHALL have parameter PIX_W, default 8, meaning pixel and output magnitude width in bits.
REQ-002 The block SHALL have parameter IMG_W, default 64, meaning pixels per image line (minimum 3).
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_pix  input  PIX_W  raster-order input pixel.
REQ-006 The block SHALL have port in_sof  input  1  marks in_pix as pixel (0,0) of a new frame.
REQ-007 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), meaning input handshake; a transfer occurs when both are high.
REQ-008 The block SHALL have port out_pix  output  PIX_W  edge magnitude.
REQ-009 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), meaning output handshake.

Function
REQ-010 The block SHALL keep two IMG_W-deep line buffers plus a 3x3 window (z1..z9, row-major, z1 top-left, z9 = newest pixel), updated only on accepted input.
REQ-011 The block SHALL keep column counter col (0..IMG_W-1) and row counter row (saturating at 2); on accept col increments, and at IMG_W-1 it wraps to 0 with row incrementing.
REQ-012 An accepted pixel with in_sof=1 SHALL be treated as (0,0), restarting col=1/row=0 after the accept; sof SHALL override a coincident wrap, and the partial previous frame SHALL be discarded.
REQ-013 A window SHALL be valid only when the accepted pixel has row>=2 and col>=2; no output SHALL be produced for the first two rows or the first two columns of each line.
REQ-014 Gx SHALL equal (z3+2*z6+z9)-(z1+2*z4+z7) and Gy SHALL equal (z7+2*z8+z9)-(z1+2*z2+z3), computed at PIX_W+3 bits signed without overflow.
REQ-015 |Gx| and |Gy| SHALL each saturate to 2^PIX_W-1, and out_pix SHALL be (sat|Gx| + sat|Gy|) >> 1 using a PIX_W+1-bit sum.
REQ-016 The datapath SHALL be a 2-stage pipeline (stage 1: |Gx|,|Gy|; stage 2: saturate/sum into out_pix), with out_valid asserted 2 cycles after the accept of a valid window when out_ready is held high.
REQ-017 The pipeline SHALL advance when !out_valid || out_ready, and in_ready SHALL equal that advance condition (combinational).
REQ-018 While out_valid=1 and out_ready=0, out_pix and out_valid SHALL hold stable and no input SHALL be accepted.
REQ-019 Sustained throughput SHALL be one pixel per cycle when in_valid and out_ready are continuously high.
REQ-020 in_sof with in_valid=0 SHALL have no effect.

Reset
REQ-021 On rst=1 at a clock edge: col=0, row=0, all stage valids=0, out_valid=0, out_pix=0, in_ready=1 in the following cycle.
REQ-022 Reset SHALL not be required to clear the line buffer or window contents; they are masked by the counters.
REQ-023 Reset mid-frame SHALL drop all in-flight results, and the next accepted pixel SHALL be treated as (0,0) regardless of in_sof.

Configuration
REQ-024 With macro SOBEL_THRESH_EN defined, the block SHALL add input thresh [PIX_W-1:0], and out_pix SHALL be all-ones when the REQ-015 value >= thresh and 0 otherwise, with latency unchanged.
REQ-025 Without SOBEL_THRESH_EN, the thresh port SHALL be absent and out_pix SHALL be the REQ-015 magnitude.

Verification
REQ-026 IMG_W=8, PIX_W=8, flat frame of 100, out_ready=1 -> 6 outputs per line from row 2 onward, all 0, each 2 cycles after its input.
REQ-027 Vertical step (cols 0-3 = 0, cols 4-7 = 255) -> Gx=1020 saturated to 255, Gy=0, out_pix=127 at windows straddling the step, 0 elsewhere.
REQ-028 Horizontal step (rows 0-3 = 0, rows 4+ = 200) -> out_pix=127 on rows 4-5, 0 elsewhere.
REQ-029 Backpressure: out_ready toggled 1-0-0-1 during streaming -> out_pix stable while stalled, in_ready=0 while stalled, no lost or duplicated outputs versus a reference model.
REQ-030 in_sof asserted at row 3, col 5, followed by rst pulsed mid-line -> no outputs until 2 new full rows plus 2 columns, and out_valid=0 the cycle after reset.
REQ-031 With SOBEL_THRESH_EN, thresh=100, vertical step frame -> out_pix=255 at step windows, 0 elsewhere.

Source files
------------

// File: rtl/sobel_stream_det_if.sv
// Pixel stream bundle for sobel_stream_det: raster input stream in, edge
// magnitude stream out, each with its own valid/ready handshake.
interface sobel_stream_det_if #(
   parameter int unsigned PIX_W = 8
);
   logic [PIX_W-1:0] in_pix;
   logic             in_sof;
   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] out_pix;
   logic             out_valid;
   logic             out_ready;

   // Source of pixels / sink of magnitudes
   modport master (
      output in_pix, in_sof, in_valid, out_ready,
      input  in_ready, out_pix, out_valid
   );

   // The filter block itself
   modport slave (
      input  in_pix, in_sof, in_valid, out_ready,
      output in_ready, out_pix, out_valid
   );
endinterface

// File: rtl/sobel_stream_det.sv
// Streaming 3x3 Sobel edge-magnitude filter.
// Two line buffers feed a 3x3 window; |Gx|,|Gy| are registered in stage 1,
// saturated and averaged into out_pix in stage 2.
// Optional macro SOBEL_THRESH_EN adds a thresh port and binarises out_pix.
module sobel_stream_det #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 64
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SOBEL_THRESH_EN
   input  logic [PIX_W-1:0] thresh,
`endif
   sobel_stream_det_if.slave bus
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned GW = PIX_W + 3;   // signed gradient width
   localparam int unsigned MW = PIX_W + 2;   // |gradient| fits in GW-1 bits

   typedef logic [PIX_W-1:0] pix_t;

   // Line buffers: lb0 holds the previous row, lb1 the row before that
   pix_t lb0 [IMG_W];
   pix_t lb1 [IMG_W];

   // Left and middle window columns; the right column comes straight from
   // the line buffers and the incoming pixel.
   pix_t w1, w2, w4, w5, w7, w8;

   logic [CW-1:0] col;
   logic [1:0]    row;

   logic          advance;
   logic          accept;
   logic [CW-1:0] eff_col;
   logic [1:0]    eff_row;
   logic          win_ok;
   pix_t          top_new;
   pix_t          mid_new;

   logic [GW-1:0] gx_p, gx_n, gy_p, gy_n, gx, gy;
   logic [GW-1:0] abs_gx, abs_gy;

   logic          s1_valid;
   logic [MW-1:0] s1_ax;
   logic [MW-1:0] s1_ay;

   pix_t          sat_x, sat_y;
   logic [PIX_W:0] mag_sum;
   pix_t          mag;
   pix_t          res;

   // Whole pipeline moves together; upstream may push whenever it moves
   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = advance;
   assign accept       = bus.in_valid && advance;

   // Position of the pixel being offered; sof forces it to (0,0)
   always_comb begin
      eff_col = col;
      eff_row = row;
      if (bus.in_sof) begin
         eff_col = '0;
         eff_row = '0;
      end
      win_ok  = (eff_row == 2'd2) && (eff_col >= CW'(2));
      top_new = lb1[eff_col];
      mid_new = lb0[eff_col];
   end

   // Sobel gradients over the window with the newest column
   always_comb begin
      gx_p   = GW'(top_new) + (GW'(mid_new) << 1) + GW'(bus.in_pix);
      gx_n   = GW'(w1) + (GW'(w4) << 1) + GW'(w7);
      gy_p   = GW'(w7) + (GW'(w8) << 1) + GW'(bus.in_pix);
      gy_n   = GW'(w1) + (GW'(w2) << 1) + GW'(top_new);
      gx     = gx_p - gx_n;
      gy     = gy_p - gy_n;
      abs_gx = gx[GW-1] ? (GW'(0) - gx) : gx;
      abs_gy = gy[GW-1] ? (GW'(0) - gy) : gy;
   end

   // Saturate each magnitude and average them
   always_comb begin
      sat_x   = (|s1_ax[MW-1:PIX_W]) ? '1 : s1_ax[PIX_W-1:0];
      sat_y   = (|s1_ay[MW-1:PIX_W]) ? '1 : s1_ay[PIX_W-1:0];
      mag_sum = (PIX_W+1)'(sat_x) + (PIX_W+1)'(sat_y);
      mag     = PIX_W'(mag_sum >> 1);
`ifdef SOBEL_THRESH_EN
      res     = (mag >= thresh) ? '1 : '0;
`else
      res     = mag;
`endif
   end

   // Column/row tracking; row saturates at 2 since only "row>=2" matters
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (bus.in_sof) begin
            col <= CW'(1);
            row <= '0;
         end else if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            if (row != 2'd2) row <= row + 2'd1;
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Line buffers and window shift on each accepted pixel; stale contents
   // after reset or sof are masked by the counters.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[eff_col] <= mid_new;
         lb0[eff_col] <= bus.in_pix;
         w1 <= w2;
         w2 <= top_new;
         w4 <= w5;
         w5 <= mid_new;
         w7 <= w8;
         w8 <= bus.in_pix;
      end
   end

   // Two-stage result pipeline, frozen while the output is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid      <= 1'b0;
         s1_ax         <= '0;
         s1_ay         <= '0;
         bus.out_valid <= 1'b0;
         bus.out_pix   <= '0;
      end else if (advance) begin
         s1_valid      <= accept && win_ok;
         s1_ax         <= abs_gx[MW-1:0];
         s1_ay         <= abs_gy[MW-1:0];
         bus.out_valid <= s1_valid;
         bus.out_pix   <= res;
      end
   end

endmodule
